i2s_rx: RTL and testbench



---
 rtl/audio_pkg.sv | 15 +
 rtl/i2s_clkgen.sv | 62 ++++++
 rtl/i2s_rx.sv | 108 ++++++++++
 tb/tb_i2s_rx.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path types and defaults, used by the I2S receiver, the volume stage
// and the downstream transmitter.
package audio_pkg;

    localparam int unsigned width_def_lp     = 24;
    localparam int unsigned slot_bits_def_lp = 32;

    typedef logic [width_def_lp-1:0] sample_t;

    typedef enum logic {
        SlotLeft  = 1'b0,
        SlotRight = 1'b1
    } slot_e;

endpackage

// File: rtl/i2s_clkgen.sv
// I2S master clock generator: divides clk_i into SCLK, counts bit slots and drives
// WS; exports rise/fall strobes and the bit position within the current slot.
module i2s_clkgen
    import audio_pkg::*;
#(
    parameter int unsigned slot_bits_p = slot_bits_def_lp,
    parameter int unsigned sclk_half_p = 2
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    output logic                           sclk_o,
    output logic                           ws_o,
    output logic                           rise_o,
    output logic                           fall_o,
    output logic [$clog2(slot_bits_p)-1:0] b_o
);

    localparam int unsigned DivW = $clog2(sclk_half_p);
    localparam int unsigned CntW = $clog2(2 * slot_bits_p);
    localparam int unsigned BW   = $clog2(slot_bits_p);

    logic [DivW-1:0] div_q, div_d;
    logic            sclk_q, sclk_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    slot_e           ws_q, ws_d;
    logic            tick_w;
    logic [CntW-1:0] b_full_w;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
            cnt_q  <= '0;
            ws_q   <= SlotLeft;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
            cnt_q  <= cnt_d;
            ws_q   <= ws_d;
        end
    end

    // WS is derived from the next count so it always agrees with cnt_q.
    always_comb begin
        tick_w = (div_q == DivW'(sclk_half_p - 1));
        div_d  = tick_w ? '0 : div_q + DivW'(1);
        sclk_d = tick_w ? ~sclk_q : sclk_q;
        rise_o = tick_w & ~sclk_q;
        fall_o = tick_w & sclk_q;
        cnt_d  = cnt_q;
        if (fall_o) begin
            cnt_d = (cnt_q == CntW'(2 * slot_bits_p - 1)) ? '0 : cnt_q + CntW'(1);
        end
        ws_d     = (cnt_d >= CntW'(slot_bits_p)) ? SlotRight : SlotLeft;
        b_full_w = (ws_q == SlotRight) ? cnt_q - CntW'(slot_bits_p) : cnt_q;
    end

    assign sclk_o = sclk_q;
    assign ws_o   = ws_q;
    assign b_o    = b_full_w[BW-1:0];

endmodule

// File: rtl/i2s_rx.sv
// I2S master receiver: deserializes left/right ADC words and presents each completed
// stereo frame on a valid/ready output register with a sticky overrun flag.
module i2s_rx
    import audio_pkg::*;
#(
    parameter int unsigned width_p     = width_def_lp,
    parameter int unsigned slot_bits_p = slot_bits_def_lp,
    parameter int unsigned sclk_half_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               sd_i,
    output logic               sclk_o,
    output logic               ws_o,
    output logic [width_p-1:0] sound_l_o,
    output logic [width_p-1:0] sound_r_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               overrun_o
);

    localparam int unsigned BW = $clog2(slot_bits_p);

    logic          rise_w, fall_w, ws_w;
    logic [BW-1:0] b_w;

    logic [width_p-1:0] shift_q, shift_d, shift_next_w;
    logic [width_p-1:0] hold_l_q, hold_l_d;
    logic               load_q, load_d;
    logic [width_p-1:0] sound_l_q, sound_l_d, sound_r_q, sound_r_d;
    logic               valid_q, valid_d, overrun_q, overrun_d;

    i2s_clkgen #(
        .slot_bits_p(slot_bits_p),
        .sclk_half_p(sclk_half_p)
    ) u_clkgen (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .sclk_o (sclk_o),
        .ws_o   (ws_w),
        .rise_o (rise_w),
        .fall_o (fall_w),
        .b_o    (b_w)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            shift_q   <= '0;
            hold_l_q  <= '0;
            load_q    <= 1'b0;
            sound_l_q <= '0;
            sound_r_q <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            hold_l_q  <= hold_l_d;
            load_q    <= load_d;
            sound_l_q <= sound_l_d;
            sound_r_q <= sound_r_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // Bit 0 of each slot is the I2S one-bit delay; bits past width_p are padding.
    always_comb begin
        shift_next_w = {shift_q[width_p-2:0], sd_i};
        shift_d      = shift_q;
        hold_l_d     = hold_l_q;
        load_d       = 1'b0;
        if (rise_w && (b_w != '0) && (b_w <= BW'(width_p))) begin
            shift_d = shift_next_w;
            if (b_w == BW'(width_p)) begin
                if (ws_w == SlotRight) begin
                    load_d = 1'b1;
                end else begin
                    hold_l_d = shift_next_w;
                end
            end
        end
    end

    // A load always wins over an accept; overrun flags a frame replaced unread.
    always_comb begin
        sound_l_d = sound_l_q;
        sound_r_d = sound_r_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (load_q) begin
            sound_l_d = hold_l_q;
            sound_r_d = shift_q;
            valid_d   = 1'b1;
            if (valid_q && !ready_i) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    assign ws_o      = ws_w;
    assign sound_l_o = sound_l_q;
    assign sound_r_o = sound_r_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx at default parameters: a cycle-counted codec model
// drives sd_i and hand-computed checks follow the timing of each frame.
module tb_i2s_rx;

    logic        clk_i;
    logic        reset_i;
    logic        sd_i;
    logic        sclk_o;
    logic        ws_o;
    logic [23:0] sound_l_o;
    logic [23:0] sound_r_o;
    logic        valid_o;
    logic        ready_i;
    logic        overrun_o;

    int errors;
    int checks;
    int e;
    int frameBase;
    logic [23:0] frameL [16];
    logic [23:0] frameR [16];
    logic        padBit [16];

    i2s_rx dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .sd_i     (sd_i),
        .sclk_o   (sclk_o),
        .ws_o     (ws_o),
        .sound_l_o(sound_l_o),
        .sound_r_o(sound_r_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .overrun_o(overrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // After edge e the bit counter equals e/4; the codec presents that bit's data.
    task automatic driveSd();
        int bc, fi, slotIdx, b;
        logic [23:0] w;
        bc      = e / 4;
        fi      = bc / 64 + frameBase;
        slotIdx = bc % 64;
        b       = slotIdx % 32;
        w       = (slotIdx < 32) ? frameL[fi] : frameR[fi];
        if (b >= 1 && b <= 24) sd_i = w[24 - b];
        else                   sd_i = padBit[fi];
    endtask

    task automatic applyStimulus(input int target);
        while (e < target) begin
            @(posedge clk_i);
            #1;
            e++;
            driveSd();
        end
    endtask

    initial begin
        clk_i     = 1'b0;
        reset_i   = 1'b0;
        sd_i      = 1'b0;
        ready_i   = 1'b1;
        errors    = 0;
        checks    = 0;
        e         = 0;
        frameBase = 0;
        for (int i = 0; i < 16; i++) begin
            frameL[i] = '0;
            frameR[i] = '0;
            padBit[i] = 1'b0;
        end
        frameL[1] = 24'hABCDEF; frameR[1] = 24'h123456;
        frameL[2] = 24'h000001; frameR[2] = 24'h800000; padBit[2] = 1'b1;
        frameL[3] = 24'h111111; frameR[3] = 24'h222222;
        frameL[4] = 24'h777777; frameR[4] = 24'h888888;
        frameL[5] = 24'h111111; frameR[5] = 24'h222222;
        frameL[6] = 24'h333333; frameR[6] = 24'h444444;
        frameL[7] = 24'hFFFFFF; frameR[7] = 24'hFFFFFF; padBit[7] = 1'b1;
        frameL[8] = 24'h5A5A5A; frameR[8] = 24'hA5A5A5;

        #12;
        checkOutput("rst_sclk",    32'(sclk_o),    32'd0);
        checkOutput("rst_ws",      32'(ws_o),      32'd0);
        checkOutput("rst_l",       32'(sound_l_o), 32'd0);
        checkOutput("rst_r",       32'(sound_r_o), 32'd0);
        checkOutput("rst_valid",   32'(valid_o),   32'd0);
        checkOutput("rst_overrun", 32'(overrun_o), 32'd0);

        @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        e = 0;
        driveSd();
        $display("[TB] reset released");

        applyStimulus(1);   checkOutput("sclk_e1", 32'(sclk_o), 32'd0);
        applyStimulus(2);   checkOutput("sclk_e2", 32'(sclk_o), 32'd1);
        applyStimulus(4);   checkOutput("sclk_e4", 32'(sclk_o), 32'd0);
        applyStimulus(6);   checkOutput("sclk_e6", 32'(sclk_o), 32'd1);
        applyStimulus(127); checkOutput("ws_e127", 32'(ws_o),   32'd0);
        applyStimulus(128); checkOutput("ws_e128", 32'(ws_o),   32'd1);

        applyStimulus(226); checkOutput("f0_valid_pre", 32'(valid_o), 32'd0);
        applyStimulus(227);
        checkOutput("f0_valid", 32'(valid_o),   32'd1);
        checkOutput("f0_l",     32'(sound_l_o), 32'd0);
        checkOutput("f0_r",     32'(sound_r_o), 32'd0);
        applyStimulus(228); checkOutput("f0_valid_post", 32'(valid_o), 32'd0);
        applyStimulus(255); checkOutput("ws_e255", 32'(ws_o), 32'd1);
        applyStimulus(256); checkOutput("ws_e256", 32'(ws_o), 32'd0);

        applyStimulus(482); checkOutput("f1_valid_pre", 32'(valid_o), 32'd0);
        applyStimulus(483);
        checkOutput("f1_valid",   32'(valid_o),   32'd1);
        checkOutput("f1_l",       32'(sound_l_o), 32'h00ABCDEF);
        checkOutput("f1_r",       32'(sound_r_o), 32'h00123456);
        checkOutput("f1_overrun", 32'(overrun_o), 32'd0);
        applyStimulus(484); checkOutput("f1_valid_post", 32'(valid_o), 32'd0);

        applyStimulus(739);
        checkOutput("f2_pad_l", 32'(sound_l_o), 32'h00000001);
        checkOutput("f2_pad_r", 32'(sound_r_o), 32'h00800000);
        checkOutput("f2_valid", 32'(valid_o),   32'd1);
        applyStimulus(740); checkOutput("f2_valid_post", 32'(valid_o), 32'd0);
        ready_i = 1'b0;

        applyStimulus(995);
        checkOutput("f3_valid",   32'(valid_o),   32'd1);
        checkOutput("f3_overrun", 32'(overrun_o), 32'd0);
        applyStimulus(1250);
        ready_i = 1'b1;
        applyStimulus(1251);
        ready_i = 1'b0;
        checkOutput("f4_valid",   32'(valid_o),   32'd1);
        checkOutput("f4_l",       32'(sound_l_o), 32'h00777777);
        checkOutput("f4_r",       32'(sound_r_o), 32'h00888888);
        checkOutput("f4_overrun", 32'(overrun_o), 32'd0);
        applyStimulus(1252);
        checkOutput("f4_hold_valid", 32'(valid_o),   32'd1);
        checkOutput("f4_hold_l",     32'(sound_l_o), 32'h00777777);
        ready_i = 1'b1;
        applyStimulus(1253);
        ready_i = 1'b0;
        checkOutput("f4_accept", 32'(valid_o), 32'd0);

        applyStimulus(1507);
        checkOutput("f5_valid",   32'(valid_o),   32'd1);
        checkOutput("f5_overrun", 32'(overrun_o), 32'd0);
        applyStimulus(1763);
        checkOutput("f6_l",       32'(sound_l_o), 32'h00333333);
        checkOutput("f6_r",       32'(sound_r_o), 32'h00444444);
        checkOutput("f6_valid",   32'(valid_o),   32'd1);
        checkOutput("f6_overrun", 32'(overrun_o), 32'd1);
        ready_i = 1'b1;
        applyStimulus(1764);
        checkOutput("f6_accept",        32'(valid_o),   32'd0);
        checkOutput("f6_overrun_stick", 32'(overrun_o), 32'd1);

        applyStimulus(1892);
        reset_i = 1'b0;
        #1;
        checkOutput("mid_rst_l",       32'(sound_l_o), 32'd0);
        checkOutput("mid_rst_r",       32'(sound_r_o), 32'd0);
        checkOutput("mid_rst_valid",   32'(valid_o),   32'd0);
        checkOutput("mid_rst_overrun", 32'(overrun_o), 32'd0);
        checkOutput("mid_rst_sclk",    32'(sclk_o),    32'd0);
        checkOutput("mid_rst_ws",      32'(ws_o),      32'd0);
        sd_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        reset_i   = 1'b1;
        e         = 0;
        frameBase = 8;
        driveSd();
        $display("[TB] reset released after mid-frame abort");

        applyStimulus(226); checkOutput("f8_valid_pre", 32'(valid_o), 32'd0);
        applyStimulus(227);
        checkOutput("f8_valid",   32'(valid_o),   32'd1);
        checkOutput("f8_l",       32'(sound_l_o), 32'h005A5A5A);
        checkOutput("f8_r",       32'(sound_r_o), 32'h00A5A5A5);
        checkOutput("f8_overrun", 32'(overrun_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
